mmio_uart_bridge: RTL and testbench
===================================

// Module: mmio_uart_bridge
// PURPOSE
// - Downstream of the CPU memory port: decodes the CPU 15-bit word address, passes RAM traffic
//   through and serves a 4-register memory-mapped serial-transmit window (FIFO + 8N1 UART TX).
// - Gives the CPU its first output device without touching the CPU or memory-controller RTL.
// - All CPU reads return with 1-cycle latency, aligned with the synchronous RAM.
// PARAMETERS
// - IO_BASE     15'h7FFC  word address of register 0; window = IO_BASE..IO_BASE+3 (4-aligned)
// - FIFO_DEPTH  8         TX FIFO entries, power of two, 2..16
// - BAUD_RESET  16'd434   BAUD_DIV reset value (clk cycles per bit)
// PORTS
// - clk        in   1   system clock, all state on rising edge
// - rst_n      in   1   asynchronous active-low reset
// - cpu_we     in   1   CPU write strobe (mem_we)
// - cpu_addr   in   15  CPU word address (mem_addr)
// - cpu_wdata  in   16  CPU write data (mem_in)
// - cpu_rdata  out  16  read data to CPU (mem_out), valid the cycle after the address
// - ram_we     out  1   cpu_we gated off inside the IO window
// - ram_addr   out  15  cpu_addr passed through unchanged
// - ram_wdata  out  16  cpu_wdata passed through unchanged
// - ram_rdata  in   16  synchronous RAM read data, 1-cycle latency
// - tx         out  1   serial line, idle high
// BEHAVIOUR
// - Reset (async, rst_n=0): tx=1, FIFO empty, UART IDLE, BAUD_DIV=BAUD_RESET, CTRL.en=0,
//   overflow=0, io_sel_q=0, rdata_q=0 -> cpu_rdata=0 until first read after release.
// - io_hit = cpu_addr[14:2]==IO_BASE[14:2]; ram_we = cpu_we & ~io_hit (combinational).
// - Read path: io_sel_q<=io_hit, rdata_q<=selected reg; cpu_rdata = io_sel_q ? rdata_q : ram_rdata.
// - Registers (offset = cpu_addr[1:0]):
//   0 DATA   W: push cpu_wdata[7:0]; R: 0
//   1 STATUS R: [0]full [1]empty [2]busy [3]overflow [8:4]count; W: 1 to bit3 clears overflow
//   2 BAUD   R/W 16-bit divisor; value 0 behaves as 1
//   3 CTRL   R/W [0]en; other bits read 0
// - Push on write to DATA when not full. Full: data dropped, overflow<=1 (sticky).
//   Push + pop same cycle while full: both occur, no overflow, count unchanged.
//   Push while empty: pop not possible that cycle (pop needs empty=0 at cycle start).
// - overflow set and clear same cycle: set wins.
// - UART FSM IDLE->START->DATA->STOP->IDLE; bit period = max(BAUD_DIV,1) clks.
//   IDLE: tx=1; if en & ~empty: pop into shift reg, ->START, baud counter loaded.
//   START: tx=0 one period. DATA: 8 bits LSB first, bit index 0..7. STOP: tx=1 one period.
//   STOP end: if en & ~empty pop and go straight to START (back-to-back, no idle gap).
// - busy = state!=IDLE. BAUD write mid-frame takes effect at the next bit boundary.
// - en cleared mid-frame: current frame completes, no further pops; FIFO contents retained.
// - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide, zero-extended in STATUS.
// - Reset mid-frame: tx returns to 1 immediately, frame aborted, FIFO flushed.
// STRUCTURE
// - mmio_pkg: register offset constants, STATUS bit positions, uart_state_t enum
//   (IDLE/START/DATA/STOP).
// - One sub-module: tx_fifo (sync FIFO, push/pop/full/empty/count, same clk/rst_n).
// - Top: address decode, register file, read mux, UART FSM + baud counter.
// TESTING
// - Reset: rst_n low mid-frame -> tx=1 same cycle, STATUS reads 16'h0002, BAUD reads BAUD_RESET.
// - Passthrough: write 16'hBEEF to 15'h0010, read back -> ram_we=1, cpu_rdata=16'hBEEF next cycle;
//   write to IO_BASE -> ram_we=0.
// - Frame: BAUD=4, CTRL=1, DATA=8'hA5 -> tx low 4 clks, bits 1,0,1,0,0,1,0,1 at 4 clks each,
//   high 4 clks; busy=1 throughout the 40 clks.
// - Overflow: en=0, 9 writes 8'h01..8'h09 -> STATUS=16'h0089 (count 8, full, overflow);
//   write 16'h0008 to STATUS -> overflow=0; enable -> 01..08 sent back-to-back, 09 never sent.
// - Full push+pop: FIFO full, push coincident with pop at STOP end -> count stays 8, overflow=0.
// - BAUD=0 -> 1 clk/bit; en cleared during bit 3 -> frame completes, next byte stays queued.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO serial-transmit bridge.
package mmio_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide synchronous FIFO; a push is accepted while full only if a pop
// happens in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// CPU memory-port bridge: RAM passthrough plus a 4-register UART TX window
// (DATA/STATUS/BAUD/CTRL) feeding an 8N1 transmitter through a FIFO.
module mmio_uart_bridge
  import mmio_pkg::*;
#(
  parameter logic [14:0] IO_BASE    = 15'h7FFC,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        io_hit, io_wr, push, pop, full, empty, busy, tick;
  logic [1:0]  off;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] count;
  logic [15:0] status, rd_val, div_m1;

  logic        io_sel_q, en_q, en_d, ovf_q, ovf_d;
  logic [15:0] rdata_q, baud_q, baud_d, cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;
  uart_state_t state_q, state_d;

  assign io_hit    = (cpu_addr[14:2] == IO_BASE[14:2]);
  assign off       = cpu_addr[1:0];
  assign io_wr     = cpu_we & io_hit;
  assign push      = io_wr & (off == OFF_DATA);
  assign ram_we    = cpu_we & ~io_hit;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign cpu_rdata = io_sel_q ? rdata_q : ram_rdata;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cpu_wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    status                    = '0;
    status[ST_FULL]           = full;
    status[ST_EMPTY]          = empty;
    status[ST_BUSY]           = busy;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT +: CNT_W]   = CNT_W'(count);
    case (off)
      OFF_DATA:   rd_val = '0;
      OFF_STATUS: rd_val = status;
      OFF_BAUD:   rd_val = baud_q;
      default:    rd_val = {15'd0, en_q};
    endcase
  end

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  always_comb begin
    baud_d = baud_q;
    en_d   = en_q;
    ovf_d  = ovf_q;
    if (io_wr && off == OFF_BAUD) baud_d = cpu_wdata;
    if (io_wr && off == OFF_CTRL) en_d = cpu_wdata[0];
    if (io_wr && off == OFF_STATUS && cpu_wdata[ST_OVF]) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  // Divisor is sampled at every bit boundary, so BAUD writes land on the next bit.
  assign div_m1 = (baud_q == '0) ? '0 : baud_q - 16'd1;
  assign tick   = (cnt_q == '0);
  assign busy   = (state_q != IDLE);
  assign tx     = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 16'd1;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (en_q && !empty) begin
          pop = 1'b1; sh_d = fifo_dout; cnt_d = div_m1; state_d = START;
        end
      end
      START: if (tick) begin
        cnt_d = div_m1; bit_d = '0; state_d = DATA;
      end
      DATA: if (tick) begin
        cnt_d = div_m1;
        sh_d  = {1'b0, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        if (en_q && !empty) begin
          pop = 1'b1; sh_d = fifo_dout; cnt_d = div_m1; state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_sel_q <= 1'b0;
      rdata_q  <= '0;
      baud_q   <= BAUD_RESET;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      bit_q    <= '0;
    end else begin
      io_sel_q <= io_hit;
      rdata_q  <= io_hit ? rd_val : '0;
      baud_q   <= baud_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench: bus passthrough rules checked every cycle, a serial-line
// receiver decoding frames, and literal register/waveform expectations.
module tb_mmio_uart_bridge;
  localparam logic [14:0] IO_BASE = 15'h7FFC;
  localparam logic [14:0] A_DATA = IO_BASE, A_STAT = IO_BASE + 15'd1;
  localparam logic [14:0] A_BAUD = IO_BASE + 15'd2, A_CTRL = IO_BASE + 15'd3;

  logic clk = 1'b0, rst_n = 1'b0, cpu_we = 1'b0;
  logic [14:0] cpu_addr = 15'h0100;
  logic [15:0] cpu_wdata = '0, cpu_rdata, ram_wdata, ram_rdata;
  logic [14:0] ram_addr;
  logic ram_we, tx;

  int checks = 0, errors = 0, cyc = 0, bit_p = 4, frame_err = 0;
  logic [7:0] rx_q[$], exp_q[$];
  int starts[$];
  logic [15:0] mem [0:255];
  logic [15:0] ram_q;
  logic last_io = 1'b0;

  mmio_uart_bridge #(.IO_BASE(IO_BASE), .FIFO_DEPTH(8), .BAUD_RESET(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with read-before-write, output cleared by reset.
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_q <= '0;
    else begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      ram_q <= mem[ram_addr[7:0]];
    end
  end
  assign ram_rdata = ram_q;

  function automatic logic in_win(input logic [14:0] a);
    return (a >= IO_BASE) && (a <= IO_BASE + 15'd3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("ram_we", ram_we, cpu_we && !in_win(cpu_addr));
    chk("ram_addr", ram_addr, cpu_addr);
    chk("ram_wdata", ram_wdata, cpu_wdata);
    if (!last_io) chk("rdata_ram", cpu_rdata, ram_rdata);
    last_io <= rst_n && in_win(cpu_addr);
  end

  // Serial receiver sampling mid-bit with the bench's idea of the bit period.
  initial begin : mon
    logic [7:0] b;
    int p, st;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        p = bit_p; st = cyc;
        repeat (p / 2) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) begin
          repeat (p) @(negedge clk);
          b[k] = tx;
        end
        repeat (p) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        repeat (p - p / 2 - 1) @(negedge clk);
        rx_q.push_back(b);
        starts.push_back(st);
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 15'h0100; cpu_wdata = '0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic rd(input string nm, input logic [14:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(nm, cpu_rdata, exp);
  endtask

  task automatic wait_rx(input int n, input int lim);
    for (int i = 0; i < lim && rx_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_rx(input string nm);
    chk({nm, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({nm, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete(); exp_q.delete(); starts.delete();
  endtask

  initial begin
    logic [7:0] a5;
    int ec;
    logic eb;
    a5 = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    @(posedge clk); #3 rst_n = 1'b1;
    rd("status_rst", A_STAT, 16'h0002);
    rd("baud_rst", A_BAUD, 16'h01B2);
    rd("ctrl_rst", A_CTRL, 16'h0000);
    rd("data_rd0", A_DATA, 16'h0000);

    // RAM passthrough, including the word just below the window
    wr(15'h0010, 16'hBEEF); @(negedge clk); chk("ram_we_hit", ram_we, 1'b1);
    rd("ram_beef", 15'h0010, 16'hBEEF);
    wr(15'h7FFB, 16'h1234); @(negedge clk); chk("ram_we_edge", ram_we, 1'b1);
    rd("ram_edge", 15'h7FFB, 16'h1234);
    wr(A_CTRL, 16'h0000); @(negedge clk); chk("ram_we_io", ram_we, 1'b0);

    // single A5 frame at 4 clk/bit
    wr(A_BAUD, 16'd4); wr(A_CTRL, 16'h0001);
    rd("baud_rw", A_BAUD, 16'd4);
    rd("ctrl_rw", A_CTRL, 16'h0001);
    bit_p = 4;
    wr(A_DATA, 16'h00A5);
    @(posedge clk); #1; cpu_we = 1'b0; cpu_addr = A_STAT;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) eb = 1'b0;
      else if (c >= 6 && c <= 37) eb = a5[(c - 6) / 4];
      else eb = 1'b1;
      chk("frame_tx", tx, eb);
      if (c >= 2) chk("frame_busy", cpu_rdata[2], (c - 1) >= 2 && (c - 1) <= 41);
    end
    exp_q.push_back(8'hA5);
    check_rx("a5");

    // overflow then back-to-back drain
    wr(A_CTRL, 16'h0000);
    for (int i = 1; i <= 9; i++) wr(A_DATA, 16'(i));
    rd("status_ovf", A_STAT, 16'h0089);
    wr(A_STAT, 16'h0008);
    rd("status_clr", A_STAT, 16'h0081);
    starts.delete();
    wr(A_CTRL, 16'h0001);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    wait_rx(8, 800);
    for (int i = 1; i < starts.size(); i++) chk("b2b_gap", starts[i] - starts[i-1], 40);
    check_rx("drain");
    repeat (4) idle();
    rd("status_drained", A_STAT, 16'h0002);

    // push coincident with the STOP-end pop while full
    wr(A_CTRL, 16'h0000);
    for (int i = 0; i < 8; i++) wr(A_DATA, 16'h10 + 16'(i));
    rd("status_full", A_STAT, 16'h0081);
    wr(A_CTRL, 16'h0001);
    idle();
    wr(A_DATA, 16'h0018);
    repeat (38) idle();
    wr(A_DATA, 16'h0019);
    rd("status_pushpop", A_STAT, 16'h0085);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
    wait_rx(10, 900);
    check_rx("pushpop");
    repeat (4) idle();
    rd("status_pp_end", A_STAT, 16'h0002);

    // BAUD=0 runs at 1 clk/bit; en dropped during bit 3
    wr(A_BAUD, 16'd0);
    rd("baud_zero", A_BAUD, 16'd0);
    bit_p = 1;
    wr(A_DATA, 16'h003C);
    wr(A_DATA, 16'h00C3);
    repeat (4) idle();
    wr(A_CTRL, 16'h0000);
    repeat (12) idle();
    rd("status_queued", A_STAT, 16'h0010);
    exp_q.push_back(8'h3C);
    check_rx("baud0");
    ec = frame_err;
    chk("framing", ec, 0);

    // reset in the middle of a start bit
    wr(A_BAUD, 16'd4); bit_p = 4;
    wr(A_CTRL, 16'h0001);
    repeat (2) idle();
    @(posedge clk); #3;
    chk("pre_rst_tx", tx, 1'b0);
    rst_n = 1'b0; #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_rdata", cpu_rdata, 16'h0000);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    rd("status_rst2", A_STAT, 16'h0002);
    rd("baud_rst2", A_BAUD, 16'h01B2);
    rd("ctrl_rst2", A_CTRL, 16'h0000);
    repeat (4) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
